// File: rtl/conv_inst_pkg.sv
// conv_inst_pkg: slot-0 control field layout, FSM state type and width helpers for conv_inst_expand.
package conv_inst_pkg;
  localparam int LOOP_EN_BIT = 0;
  localparam int KH_LSB = 1;
  localparam int KB_DEF = 2;
  localparam int KW_LSB = KH_LSB + KB_DEF;
  localparam int DIM0_LSB = KW_LSB + KB_DEF;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic int kw_lsb(input int kb);
    return KH_LSB + kb;
  endfunction
  function automatic int dim0_lsb(input int kb);
    return KH_LSB + 2 * kb;
  endfunction
  function automatic int beat_w(input int kb);
    return 2 * kb;
  endfunction
endpackage

// File: rtl/conv_inst_addr_gen.sv
// conv_inst_addr_gen: row/column tap counters with accumulated offsets.
// Counters track the beat currently in the output register; outputs describe the next beat.
module conv_inst_addr_gen
  import conv_inst_pkg::*;
#(
  parameter int KB = 2,
  parameter int DW = 7,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_adv,
  input  logic [KB-1:0] i_kh_m1,
  input  logic [KB-1:0] i_kw_m1,
  input  logic [DW-1:0] i_dim0,
  output logic [AW-1:0] o_off2d,
  output logic [AW-1:0] o_lin,
  output logic          o_last
);
  localparam int BW = beat_w(KB);
  logic [KB-1:0] r_r, r_c, w_r_nx, w_c_nx;
  logic [AW-1:0] r_row_off, w_row_nx;
  logic [BW-1:0] r_n, w_n_nx;
  logic w_col_wrap;
  always_comb begin
    w_col_wrap = r_c == i_kw_m1;
    w_c_nx = w_col_wrap ? '0 : r_c + 1'b1;
    w_r_nx = w_col_wrap ? r_r + 1'b1 : r_r;
    w_row_nx = w_col_wrap ? r_row_off + AW'(i_dim0) : r_row_off;
    w_n_nx = r_n + 1'b1;
  end
  assign o_off2d = w_row_nx + AW'(w_c_nx);
  assign o_lin = AW'(w_n_nx);
  assign o_last = (w_r_nx == i_kh_m1) && (w_c_nx == i_kw_m1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r <= '0;
      r_c <= '0;
      r_row_off <= '0;
      r_n <= '0;
    end else if (i_clear) begin
      r_r <= '0;
      r_c <= '0;
      r_row_off <= '0;
      r_n <= '0;
    end else if (i_adv) begin
      r_r <= w_r_nx;
      r_c <= w_c_nx;
      r_row_off <= w_row_nx;
      r_n <= w_n_nx;
    end
  end
endmodule

// File: rtl/conv_inst_expand.sv
// conv_inst_expand: replays one instruction bundle as KHxKW beats with per-slot tap-offset addresses.
// Optional CONV_INST_EXPAND_PERF_EN adds a saturating handshake counter on perf_beats.
module conv_inst_expand
  import conv_inst_pkg::*;
#(
  parameter int IRW = 30,
  parameter int IN = 3,
  parameter int AW = 14,
  parameter int DW = 7,
  parameter int KB = 2,
  parameter int BASE_LSB = 16,
  parameter logic [IN-1:0] ADDR_MASK = 3'b011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IRW*IN-1:0] m_inst,
  input  logic              m_valid,
  output logic              m_ready,
  output logic [IRW*IN-1:0] s_inst,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              s_last
`ifdef CONV_INST_EXPAND_PERF_EN
  ,output logic [31:0]      perf_beats
`endif
);
  localparam int KW_L = kw_lsb(KB);
  localparam int DIM_L = dim0_lsb(KB);
  state_t r_state, w_state_nx;
  logic [IRW*IN-1:0] r_bundle, r_s_inst, w_beat;
  logic r_s_valid, r_s_last;
  logic w_load_ok, w_acc, w_adv, w_first_last, w_ag_last;
  logic [AW-1:0] w_off2d, w_lin;
  assign w_load_ok = !r_s_valid || s_ready;
  assign m_ready = (r_state == ST_IDLE) && w_load_ok;
  assign w_acc = m_valid && m_ready;
  assign w_adv = (r_state == ST_RUN) && w_load_ok;
  assign w_first_last = !m_inst[LOOP_EN_BIT] || (m_inst[KH_LSB +: KB] == '0 && m_inst[KW_L +: KB] == '0);
  conv_inst_addr_gen #(.KB(KB), .DW(DW), .AW(AW)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_acc),
    .i_adv   (w_adv),
    .i_kh_m1 (r_bundle[KH_LSB +: KB]),
    .i_kw_m1 (r_bundle[KW_L +: KB]),
    .i_dim0  (r_bundle[DIM_L +: DW]),
    .o_off2d (w_off2d),
    .o_lin   (w_lin),
    .o_last  (w_ag_last)
  );
  always_comb begin
    w_state_nx = r_state == ST_IDLE ? ((w_acc && !w_first_last) ? ST_RUN : ST_IDLE)
                                    : ((w_adv && w_ag_last) ? ST_IDLE : ST_RUN);
  end
  always_comb begin
    w_beat = r_bundle;
    for (int k = 0; k < IN; k++)
      w_beat[IRW*k+BASE_LSB +: AW] = r_bundle[IRW*k+BASE_LSB +: AW] + (ADDR_MASK[k] ? w_off2d : w_lin);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bundle <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_acc) r_bundle <= m_inst;
    end
  end
  // Beat 0 always carries zero offset, so the accepted bundle loads straight into the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_inst <= '0;
      r_s_valid <= 1'b0;
      r_s_last <= 1'b0;
    end else if (w_acc) begin
      r_s_inst <= m_inst;
      r_s_valid <= 1'b1;
      r_s_last <= w_first_last;
    end else if (w_adv) begin
      r_s_inst <= w_beat;
      r_s_valid <= 1'b1;
      r_s_last <= w_ag_last;
    end else if (r_s_valid && s_ready) begin
      r_s_valid <= 1'b0;
      r_s_last <= 1'b0;
    end
  end
  assign s_inst = r_s_inst;
  assign s_valid = r_s_valid;
  assign s_last = r_s_last;
`ifdef CONV_INST_EXPAND_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_perf <= '0;
    else if (r_s_valid && s_ready && r_perf != 32'hFFFF_FFFF) r_perf <= r_perf + 1'b1;
  end
  assign perf_beats = r_perf;
`else
`endif
endmodule

// File: tb/tb_conv_inst_expand.sv
// tb_conv_inst_expand: directed scenario tasks for conv_inst_expand with hand-derived expectations.
module tb_conv_inst_expand;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [89:0] m_inst = '0;
  logic m_valid = 1'b0;
  logic m_ready;
  logic [89:0] s_inst;
  logic s_valid;
  logic s_ready = 1'b1;
  logic s_last;
  int checks = 0;
  int errors = 0;

  conv_inst_expand dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_inst  (m_inst),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .s_inst  (s_inst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last)
  );

  always #5 clk = ~clk;

  function automatic logic [89:0] mk(input logic le, input int kh, input int kw, input int dim0,
                                     input int b0, input int b1, input int b2);
    logic [89:0] v;
    v = '0;
    v[0] = le;
    v[2:1] = kh[1:0];
    v[4:3] = kw[1:0];
    v[11:5] = dim0[6:0];
    v[15:12] = 4'h9;
    v[29:16] = b0[13:0];
    v[45:30] = 16'hA5C3;
    v[59:46] = b1[13:0];
    v[75:60] = 16'h3C5A;
    v[89:76] = b2[13:0];
    return v;
  endfunction

  // Slots 0 and 1 take the 2-D offset, slot 2 the linear beat index.
  function automatic logic [89:0] exp_beat(input logic [89:0] b, input int off, input int lin);
    logic [89:0] e;
    logic [13:0] base, add;
    e = b;
    for (int i = 0; i < 3; i++) begin
      base = b[30*i+16 +: 14];
      add = (i < 2) ? off[13:0] : lin[13:0];
      e[30*i+16 +: 14] = base + add;
    end
    return e;
  endfunction

  task automatic drive_bundle(input logic [89:0] b);
    int k;
    m_inst = b;
    m_valid = 1'b1;
    k = 0;
    while (!m_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout m_ready got %b exp 1", m_ready);
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %b exp 0", s_valid); end
    checks++; if (s_last !== 1'b0) begin errors++; $display("FAIL reset_s_last got %b exp 0", s_last); end
    checks++; if (s_inst !== 90'd0) begin errors++; $display("FAIL reset_s_inst got %h exp 0", s_inst); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_m_ready got %b exp 1", m_ready); end
  endtask

  task automatic test_passthrough();
    logic [89:0] b;
    b = mk(1'b0, 2, 2, 10, 100, 200, 300);
    drive_bundle(b);
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b exp 1", s_valid); end
    checks++; if (s_inst !== b) begin errors++; $display("FAIL pass_inst got %h exp %h", s_inst, b); end
    checks++; if (s_last !== 1'b1) begin errors++; $display("FAIL pass_last got %b exp 1", s_last); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL pass_m_ready got %b exp 1", m_ready); end
    @(posedge clk); #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got %b exp 0", s_valid); end
  endtask

  task automatic test_3x3();
    logic [89:0] b, e;
    int s0 [9] = '{100, 101, 102, 110, 111, 112, 120, 121, 122};
    b = mk(1'b1, 2, 2, 10, 100, 200, 300);
    drive_bundle(b);
    for (int n = 0; n < 9; n++) begin
      e = exp_beat(b, (n / 3) * 10 + (n % 3), n);
      checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL k3_valid beat %0d got %b exp 1", n, s_valid); end
      checks++; if (s_inst !== e) begin errors++; $display("FAIL k3_inst beat %0d got %h exp %h", n, s_inst, e); end
      checks++; if (s_inst[29:16] !== 14'(s0[n])) begin errors++; $display("FAIL k3_slot0 beat %0d got %0d exp %0d", n, s_inst[29:16], s0[n]); end
      checks++; if (s_inst[89:76] !== 14'(300 + n)) begin errors++; $display("FAIL k3_slot2 beat %0d got %0d exp %0d", n, s_inst[89:76], 300 + n); end
      checks++; if (s_last !== (n == 8)) begin errors++; $display("FAIL k3_last beat %0d got %b exp %b", n, s_last, n == 8); end
      checks++; if (m_ready !== (n == 8)) begin errors++; $display("FAIL k3_m_ready beat %0d got %b exp %b", n, m_ready, n == 8); end
      @(posedge clk); #1;
    end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL k3_drain got %b exp 0", s_valid); end
  endtask

  task automatic test_1x1();
    logic [89:0] b;
    b = mk(1'b1, 0, 0, 10, 50, 60, 70);
    drive_bundle(b);
    checks++; if (s_inst !== b) begin errors++; $display("FAIL k1_inst got %h exp %h", s_inst, b); end
    checks++; if (s_last !== 1'b1) begin errors++; $display("FAIL k1_last got %b exp 1", s_last); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL k1_m_ready got %b exp 1", m_ready); end
    @(posedge clk); #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL k1_drain got %b exp 0", s_valid); end
  endtask

  task automatic test_backpressure();
    logic [89:0] b, e;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int got, k;
    b = mk(1'b1, 2, 2, 10, 100, 200, 300);
    drive_bundle(b);
    got = 0;
    k = 0;
    while (got < 9 && k < 100) begin
      s_ready = pat[k % 4];
      e = exp_beat(b, (got / 3) * 10 + (got % 3), got);
      checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_valid beat %0d got %b exp 1", got, s_valid); end
      checks++; if (s_inst !== e) begin errors++; $display("FAIL bp_inst beat %0d got %h exp %h", got, s_inst, e); end
      checks++; if (s_last !== (got == 8)) begin errors++; $display("FAIL bp_last beat %0d got %b exp %b", got, s_last, got == 8); end
      if (s_ready) got++;
      @(posedge clk); #1;
      k++;
    end
    s_ready = 1'b1;
    checks++; if (got != 9) begin errors++; $display("FAIL bp_count got %0d exp 9", got); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", s_valid); end
  endtask

  task automatic test_wrap();
    logic [89:0] b, e;
    int s0 [4] = '{16380, 16381, 6, 7};
    int offs [4] = '{0, 1, 10, 11};
    b = mk(1'b1, 1, 1, 10, 16380, 200, 300);
    drive_bundle(b);
    for (int n = 0; n < 4; n++) begin
      e = exp_beat(b, offs[n], n);
      checks++; if (s_inst[29:16] !== 14'(s0[n])) begin errors++; $display("FAIL wrap_slot0 beat %0d got %0d exp %0d", n, s_inst[29:16], s0[n]); end
      checks++; if (s_inst !== e) begin errors++; $display("FAIL wrap_inst beat %0d got %h exp %h", n, s_inst, e); end
      checks++; if (s_last !== (n == 3)) begin errors++; $display("FAIL wrap_last beat %0d got %b exp %b", n, s_last, n == 3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [89:0] a, b, e;
    int offs [4] = '{0, 1, 5, 6};
    a = mk(1'b1, 1, 1, 5, 1000, 2000, 3000);
    b = mk(1'b1, 0, 1, 3, 40, 50, 60);
    drive_bundle(a);
    for (int n = 0; n < 4; n++) begin
      e = exp_beat(a, offs[n], n);
      checks++; if (s_inst !== e) begin errors++; $display("FAIL b2b_a_inst beat %0d got %h exp %h", n, s_inst, e); end
      if (n == 3) begin
        m_inst = b;
        m_valid = 1'b1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL b2b_m_ready got %b exp 1", m_ready); end
      end
      @(posedge clk); #1;
    end
    m_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      e = exp_beat(b, n, n);
      checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL b2b_b_valid beat %0d got %b exp 1", n, s_valid); end
      checks++; if (s_inst !== e) begin errors++; $display("FAIL b2b_b_inst beat %0d got %h exp %h", n, s_inst, e); end
      checks++; if (s_last !== (n == 1)) begin errors++; $display("FAIL b2b_b_last beat %0d got %b exp %b", n, s_last, n == 1); end
      @(posedge clk); #1;
    end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", s_valid); end
  endtask

  task automatic test_reset_mid();
    logic [89:0] b, b2, e;
    int offs [4] = '{0, 1, 10, 11};
    b = mk(1'b1, 2, 2, 10, 100, 200, 300);
    drive_bundle(b);
    repeat (4) begin
      @(posedge clk); #1;
    end
    e = exp_beat(b, 11, 4);
    checks++; if (s_inst !== e) begin errors++; $display("FAIL rst_pre_inst got %h exp %h", s_inst, e); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", s_valid); end
    checks++; if (s_inst !== 90'd0) begin errors++; $display("FAIL rst_mid_inst got %h exp 0", s_inst); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_m_ready got %b exp 1", m_ready); end
    b2 = mk(1'b1, 1, 1, 10, 500, 600, 700);
    drive_bundle(b2);
    for (int n = 0; n < 4; n++) begin
      e = exp_beat(b2, offs[n], n);
      checks++; if (s_inst !== e) begin errors++; $display("FAIL rst_next_inst beat %0d got %h exp %h", n, s_inst, e); end
      checks++; if (s_last !== (n == 3)) begin errors++; $display("FAIL rst_next_last beat %0d got %b exp %b", n, s_last, n == 3); end
      @(posedge clk); #1;
    end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_next_drain got %b exp 0", s_valid); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_3x3();
    test_1x1();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_inst_expand.md
# conv_inst_expand

Parametrised convolution instruction expander. It accepts one packed instruction bundle of IN slots and replays it as KH×KW beats, one per kernel tap. Each beat carries per-slot base addresses advanced by a 2-D tap offset (feature slots) or a linear tap index (weight slots). It sits between the instruction decoder and the conv datapath, and replaces the fixed 3×3 loop with runtime kernel size, per-slot addressing mode and a last-beat marker.

## Interface
- IRW, 30, bits per instruction slot
- IN, 3, slots per bundle
- AW, 14, address field width
- DW, 7, row-stride (dim0 size) field width
- KB, 2, kernel-dimension field width; max kernel 2^KB
- BASE_LSB, 16, LSB of base address field in every slot (BASE_LSB+AW ≤ IRW)
- ADDR_MASK, 3'b011, bit i=1: slot i uses the 2-D offset; bit i=0: slot i uses the linear offset
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- m_inst  input  IRW*IN  input bundle; slot i = m_inst[IRW*i +: IRW]
- m_valid  input  1  bundle valid
- m_ready  output  1  bundle accepted when m_valid&&m_ready
- s_inst  output  IRW*IN  expanded beat
- s_valid  output  1  beat valid
- s_ready  input  1  downstream ready
- s_last  output  1  final beat of current bundle

## Operation
- Slot-0 control fields: [0] loop_en; [KB:1] kh_m1; [2KB:KB+1] kw_m1; [2KB+DW:2KB+1] dim0 (row stride).
- loop_en=0: single beat, bundle forwarded unmodified, s_last=1.
- loop_en=1: beats n=0..(kh_m1+1)(kw_m1+1)-1, row r outer, column c inner. Per beat:
  - masked slots: base += r*dim0 + c
  - unmasked slots: base += n
  - all other bits copied unchanged.
- Address add is modulo 2^AW (wrap, no saturation). Offsets come from accumulators (row_off += dim0 per row advance), not multipliers.
- FSM: IDLE (no beats pending beyond the output register) and RUN (beats remain after the current one). IDLE→RUN on accept with total beats > 1. RUN→IDLE when the beat with s_last is loaded.
- m_ready = (state==IDLE) && (!s_valid || s_ready). A new bundle can be accepted in the same cycle the last beat leaves.
- Bundle register is captured only on accept. Counters are cleared on accept.

## Timing
- Reset: s_valid=0, s_last=0, s_inst=0, FSM=IDLE, counters=0; therefore m_ready=1.
- Latency: bundle accepted at edge N gives beat 0 on s_* after edge N (one register stage). No combinational path from m_* to s_*.
- Throughput: one beat per cycle while s_ready=1. A back-to-back bundle gap is 0 cycles.
- Stall: while s_valid && !s_ready, s_inst, s_last and counters hold. AXI rules apply: s_valid never drops without a handshake.
- s_valid falls only after the s_last beat handshakes with no new accept in that cycle.
- A 1×1 kernel with loop_en=1 gives one beat, offset 0, s_last=1, and stays in IDLE.
- Reset asserted mid-bundle discards remaining beats immediately (asynchronous).

## Configuration
- CONV_INST_EXPAND_PERF_EN defined: adds output perf_beats [31:0]. It counts s_valid&&s_ready handshakes, saturates at 2^32-1, and resets to 0.
- Undefined: the port and counter do not exist. Functional behaviour is identical.

## Structure
- Package conv_inst_pkg holds:
  - slot-0 field LSB/width constants (LOOP_EN_BIT, KH_LSB, KW_LSB, DIM0_LSB)
  - FSM state typedef (ST_IDLE, ST_RUN)
  - beat-count width function.
- Sub-module conv_inst_addr_gen: r/c counters, 2-D and linear offsets, last flag, advance/clear inputs. The top holds the bundle register, output stage, FSM and per-slot adders.

## Test plan
- Passthrough: loop_en=0, slot bases 100/200/300 -> one beat, identical bundle, s_last=1; m_ready high next cycle.
- 3×3, dim0=10, bases 100/200/300 -> 9 beats:
  - slots 0/1 bases 100,101,102,110,111,112,120,121,122 (200+ same offsets)
  - slot 2 bases 300..308
  - s_last only on beat 9.
- Back-pressure: 3×3 with s_ready toggling 1,0,0,1 -> each beat holds stable while stalled; same 9-beat sequence, no loss or duplication.
- Wrap: AW=14, slot-0 base 16380, 2×2, dim0=10 -> bases 16380,16381,6,7.
- Back-to-back: second bundle presented during the first's s_last beat with s_ready=1 -> accepted that cycle; its beat 0 on the next cycle, no bubble.
- Reset at beat 4 of 9 -> s_valid=0 immediately, m_ready=1 after release; next bundle starts at beat 0.
